// File: rtl/riscv_pkg.sv
// Shared front-end definitions: ISA widths, PC step and the
// {pc, instr} bundle buffered between memory and fetch.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and synchronous flush.
// Flush wins over push and pop; push into a full FIFO needs a pop.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q];
    assign count   = count_q;
    assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/imem_prefetch_queue.sv
// Sequential instruction prefetcher: credit-limited request issue,
// in-order response buffering and redirect flush with discard count.
module imem_prefetch_queue
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   occ;
    logic [CW:0]     credit_used;
    logic [XLEN-1:0] target;
    logic            fire;
    logic            push;
    logic            pop;
    logic            empty;
    logic            full;
    fetch_entry_t    wentry;
    fetch_entry_t    head;

    assign target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign credit_used = {1'b0, occ} + {1'b0, outst_q};

    assign imem_req  = !reset && !redirect_en
                     && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign fire      = imem_req && imem_gnt;

    assign push   = imem_rvalid && (discard_q == '0) && !redirect_en;
    assign wentry = '{pc: resp_pc_q, instr: imem_rdata};

    assign instr_valid = !reset && !empty;
    assign pop         = instr_valid && instr_ready;
    assign instr       = reset ? '0 : head.instr;
    assign instr_pc    = reset ? '0 : head.pc;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_en),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (occ)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        outst_d    = outst_q + CW'(fire) - CW'(imem_rvalid);
        if (redirect_en) begin
            // everything still in flight after this cycle is stale
            fetch_pc_d = target;
            resp_pc_d  = target;
            discard_d  = outst_d;
        end else begin
            if (fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (imem_rvalid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - 1'b1;
                end else begin
                    resp_pc_d = resp_pc_q + PC_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid |-> (outst_q != '0));

    a_aligned: assert property (@(posedge clk) disable iff (reset)
        redirect_en |-> (redirect_pc[1:0] == 2'b00));

    a_credit: assert property (@(posedge clk) disable iff (reset)
        credit_used <= (CW+1)'(DEPTH));

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (push && full) |-> pop);

endmodule

// File: tb/tb_imem_prefetch_queue.sv
// Directed bench for the prefetch queue with an in-order memory model
// of configurable latency and grant/response stall rates.
module tb_imem_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    imem_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rq_t;

    rq_t         q[$];
    logic [31:0] gaddr[$];
    int          gcyc[$];
    logic [31:0] opc[$];
    logic [31:0] oins[$];
    int          ocyc[$];

    int cyc = 0;
    int lat = 1;
    int gnt_pct = 100;
    int rv_pct = 100;
    int n_chk = 0;
    int n_err = 0;

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_instr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        gaddr.delete();
        gcyc.delete();
        opc.delete();
        oins.delete();
        ocyc.delete();
    endtask

    // one clock: drive memory side, sample DUT, update model at the edge
    task automatic step();
        rq_t r;
        #1;
        imem_gnt = (int'($urandom_range(99)) < gnt_pct);
        if (q.size() > 0 && q[0].due <= cyc
            && int'($urandom_range(99)) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom();
        end
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = instr_valid;
        s_pc    = instr_pc;
        s_instr = instr;
        @(posedge clk);
        if (imem_rvalid) void'(q.pop_front());
        if (s_req && imem_gnt) begin
            r.addr = s_addr;
            r.due  = cyc + lat;
            q.push_back(r);
            gaddr.push_back(s_addr);
            gcyc.push_back(cyc);
        end
        if (s_valid && instr_ready && !redirect_en) begin
            opc.push_back(s_pc);
            oins.push_back(s_instr);
            ocyc.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // hold reset until the memory has returned everything in flight
    task automatic do_reset();
        int k;
        reset       = 1'b1;
        redirect_en = 1'b0;
        rv_pct      = 100;
        k = 0;
        while ((q.size() > 0 || k < 2) && k < 50) begin
            step();
            k++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int mark, gmark, bad, ptr, viol, npop;
        logic [31:0] exp_pc, tgt;
        logic redir;

        reset       = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        @(negedge clk);
        run(3);
        chk("rst_req", 32'(s_req), 0);
        chk("rst_valid", 32'(s_valid), 0);
        chk("rst_instr", s_instr, 0);
        chk("rst_pc", s_pc, 0);

        // streaming, latency 1
        clr();
        reset = 1'b0;
        run(10);
        chk("t1_g0", gaddr[0], 32'h0);
        chk("t1_g1", gaddr[1], 32'h4);
        chk("t1_g2", gaddr[2], 32'h8);
        chk("t1_gcyc1", gcyc[1] - gcyc[0], 1);
        chk("t1_gcyc2", gcyc[2] - gcyc[0], 2);
        chk("t1_first", ocyc[0] - gcyc[0], 2);
        chk("t1_pc0", opc[0], 32'h0);
        chk("t1_ins0", oins[0], 32'h1000_0000);
        for (int i = 1; i < 5; i++) begin
            chk("t1_pc", opc[i], 32'(4 * i));
            chk("t1_rate", ocyc[i] - ocyc[0], i);
        end

        // back-pressure fills the credit window
        do_reset();
        clr();
        instr_ready = 1'b0;
        reset = 1'b0;
        run(10);
        chk("t2_ngnt", gaddr.size(), 4);
        chk("t2_g3", gaddr[3], 32'hC);
        chk("t2_req", 32'(s_req), 0);
        chk("t2_valid", 32'(s_valid), 1);
        chk("t2_headpc", s_pc, 32'h0);
        chk("t2_nopop", opc.size(), 0);
        instr_ready = 1'b1;
        run(8);
        for (int i = 0; i < 4; i++) begin
            chk("t2_pc", opc[i], 32'(4 * i));
            chk("t2_ins", oins[i], 32'h1000_0000 + 32'(i));
        end
        chk("t2_resume", gaddr[4], 32'h10);

        // latency 3, redirect with 2 in flight and 1 buffered
        do_reset();
        clr();
        lat = 3;
        instr_ready = 1'b0;
        reset = 1'b0;
        run(3);
        gnt_pct = 0;
        step();
        gnt_pct = 100;
        redirect_en = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect_en = 1'b0;
        instr_ready = 1'b1;
        step();
        chk("t3_valid_n1", 32'(s_valid), 0);
        run(12);
        chk("t3_pc0", opc[0], 32'h200);
        chk("t3_ins0", oins[0], memf(32'h200));
        chk("t3_pc1", opc[1], 32'h204);
        chk("t3_gnt", gaddr[3], 32'h200);
        bad = 0;
        foreach (opc[i]) if (opc[i] < 32'h200) bad++;
        chk("t3_stale", bad, 0);

        // redirect coinciding with rvalid and gnt, then back-to-back
        do_reset();
        clr();
        lat = 2;
        instr_ready = 1'b1;
        reset = 1'b0;
        run(8);
        mark  = opc.size();
        gmark = gaddr.size();
        redirect_en = 1'b1;
        redirect_pc = 32'h100;
        step();
        chk("t4_rv", 32'(imem_rvalid), 1);
        chk("t4_gnt_void", gaddr.size(), gmark);
        redirect_en = 1'b0;
        run(10);
        chk("t4_pc0", opc[mark], 32'h100);
        chk("t4_pc1", opc[mark + 1], 32'h104);
        chk("t4_ins0", oins[mark], memf(32'h100));
        chk("t4_g0", gaddr[gmark], 32'h100);
        mark  = opc.size();
        gmark = gaddr.size();
        redirect_en = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect_pc = 32'h400;
        step();
        redirect_en = 1'b0;
        run(10);
        chk("t4_bb_pc", opc[mark], 32'h400);
        chk("t4_bb_g", gaddr[gmark], 32'h400);
        bad = 0;
        for (int i = mark; i < opc.size(); i++)
            if (opc[i] >= 32'h300 && opc[i] < 32'h400) bad++;
        chk("t4_bb_stale", bad, 0);

        // random stalls and redirects
        do_reset();
        clr();
        lat = 2;
        gnt_pct = 70;
        rv_pct = 70;
        reset = 1'b0;
        bad = 0;
        viol = 0;
        ptr = 0;
        npop = 0;
        exp_pc = '0;
        for (int i = 0; i < 3000; i++) begin
            instr_ready = (int'($urandom_range(99)) < 60);
            redir = (i == 0) || (int'($urandom_range(99)) < 2);
            tgt = $urandom() & 32'hFFFF_FFFC;
            redirect_en = redir;
            redirect_pc = tgt;
            step();
            if (q.size() > 4) viol++;
            while (ptr < opc.size()) begin
                if (opc[ptr] !== exp_pc || oins[ptr] !== memf(exp_pc))
                    bad++;
                exp_pc = exp_pc + 32'd4;
                ptr++;
                npop++;
            end
            if (redir) exp_pc = tgt;
        end
        redirect_en = 1'b0;
        gnt_pct = 100;
        chk("t5_seq", bad, 0);
        chk("t5_credit", viol, 0);
        chk("t5_progress", 32'(npop > 500), 1);

        // reset with the FIFO full, then wrap
        do_reset();
        clr();
        lat = 1;
        instr_ready = 1'b0;
        reset = 1'b0;
        run(10);
        chk("t6_full", 32'(s_valid), 1);
        reset = 1'b1;
        step();
        chk("t6_valid", 32'(s_valid), 0);
        chk("t6_req", 32'(s_req), 0);
        do_reset();
        clr();
        instr_ready = 1'b1;
        reset = 1'b0;
        run(6);
        chk("t6_restart_g", gaddr[0], 32'h0);
        chk("t6_restart_pc", opc[0], 32'h0);
        mark = opc.size();
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_en = 1'b0;
        run(8);
        chk("t6_wrap0", opc[mark], 32'hFFFF_FFF8);
        chk("t6_wrap1", opc[mark + 1], 32'hFFFF_FFFC);
        chk("t6_wrap2", opc[mark + 2], 32'h0);
        chk("t6_wrap_ins", oins[mark + 2], memf(32'h0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
